// File: rtl/uart_pkg.sv
// Register offsets, bit positions, AXI response codes and FSM encodings
// shared by the AXI-Lite UART controller.
package uart_pkg;

  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;
  localparam logic [3:0] OFF_IRQ    = 4'hC;

  localparam int STAT_TXRDY     = 0;
  localparam int STAT_RXVAL     = 1;
  localparam int STAT_ERR       = 2;
  localparam int CTRL_TXEN      = 0;
  localparam int CTRL_RXEN      = 1;
  localparam int CTRL_IRQEN_LSB = 2;
  localparam int CTRL_BAUD_LSB  = 16;
  localparam int IRQ_ERR        = 2;

  // Only tx_en, rx_en, irq_en and baud_div are implemented in CTRL.
  localparam logic [31:0] CTRL_MASK = 32'hFFFF_001F;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_TX,
    W_RESP
  } wstate_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_POP,
    R_RESP
  } rstate_e;

endpackage

// File: rtl/uart_axil_ctrl.sv
// AXI-Lite register front end for a UART: DATA/STATUS/CTRL/IRQ registers,
// independent write and read FSMs bridging to TX/RX byte streams.
module uart_axil_ctrl
  import uart_pkg::*;
#(
  parameter int                  AXI_ALEN  = 32,
  parameter int                  AXI_DLEN  = 32,
  parameter int                  UART_DLEN = 8,
  parameter logic [AXI_ALEN-1:0] BASE_ADDR = '0
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_axi_awvalid,
  output logic                    o_axi_awready,
  input  logic [AXI_ALEN-1:0]     i_axi_awaddr,
  input  logic                    i_axi_wvalid,
  output logic                    o_axi_wready,
  input  logic [AXI_DLEN-1:0]     i_axi_wdata,
  input  logic [AXI_DLEN/8-1:0]   i_axi_wstrb,
  output logic                    o_axi_bvalid,
  input  logic                    i_axi_bready,
  output logic [1:0]              o_axi_bresp,
  input  logic                    i_axi_arvalid,
  output logic                    o_axi_arready,
  input  logic [AXI_ALEN-1:0]     i_axi_araddr,
  output logic                    o_axi_rvalid,
  input  logic                    i_axi_rready,
  output logic [AXI_DLEN-1:0]     o_axi_rdata,
  output logic [1:0]              o_axi_rresp,
  output logic                    o_txb_tvalid,
  input  logic                    i_txb_tready,
  output logic [UART_DLEN-1:0]    o_txb_tdata,
  input  logic                    i_rxb_tvalid,
  output logic                    o_rxb_tready,
  input  logic [UART_DLEN-1:0]    i_rxb_tdata,
  input  logic                    i_rx_err,
  output logic                    o_irq,
  output logic                    o_tx_en,
  output logic                    o_rx_en,
  output logic [15:0]             o_baud_div
);

  logic                   ready_q;
  wstate_e                wstate_q, wstate_d;
  logic                   aw_got_q, aw_got_d;
  logic                   w_got_q, w_got_d;
  logic [AXI_ALEN-1:0]    awaddr_q, awaddr_d;
  logic [AXI_DLEN-1:0]    wdata_q, wdata_d;
  logic [AXI_DLEN/8-1:0]  wstrb_q, wstrb_d;
  logic [1:0]             bresp_q, bresp_d;
  logic [UART_DLEN-1:0]   tdata_q, tdata_d;
  logic [AXI_DLEN-1:0]    ctrl_q, ctrl_d;
  logic                   err_q, err_d;
  logic                   err_clr;
  logic                   irq_q;
  rstate_e                rstate_q, rstate_d;
  logic [AXI_DLEN-1:0]    rdata_q, rdata_d;
  logic [1:0]             rresp_q, rresp_d;
  logic [AXI_DLEN-1:0]    wmask;
  logic [AXI_DLEN-1:0]    status_val;
  logic [2:0]             pending_d;

  function automatic logic in_window(input logic [AXI_ALEN-1:0] addr);
    return addr[AXI_ALEN-1:4] == BASE_ADDR[AXI_ALEN-1:4];
  endfunction

  always_comb begin
    wmask = '0;
    for (int i = 0; i < AXI_DLEN / 8; i++) begin
      wmask[8*i +: 8] = {8{wstrb_q[i]}};
    end
  end

  assign status_val = {{(AXI_DLEN-3){1'b0}}, err_q, i_rxb_tvalid, i_txb_tready};
  assign err_d      = i_rx_err | (err_q & ~err_clr);
  assign pending_d  = {err_d, i_rxb_tvalid, i_txb_tready};

  // Write path: collect AW and W in any order, decode once both are held.
  always_comb begin
    wstate_d = wstate_q;
    aw_got_d = aw_got_q;
    w_got_d  = w_got_q;
    awaddr_d = awaddr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bresp_d  = bresp_q;
    tdata_d  = tdata_q;
    ctrl_d   = ctrl_q;
    err_clr  = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (o_axi_awready && i_axi_awvalid) begin
          aw_got_d = 1'b1;
          awaddr_d = i_axi_awaddr;
        end
        if (o_axi_wready && i_axi_wvalid) begin
          w_got_d = 1'b1;
          wdata_d = i_axi_wdata;
          wstrb_d = i_axi_wstrb;
        end
        if (aw_got_q && w_got_q) begin
          aw_got_d = 1'b0;
          w_got_d  = 1'b0;
          wstate_d = W_RESP;
          if (!in_window(awaddr_q)) begin
            bresp_d = RESP_DECERR;
          end else begin
            case (awaddr_q[3:0])
              OFF_DATA: begin
                if (wstrb_q[0] && ctrl_q[CTRL_TXEN]) begin
                  wstate_d = W_TX;
                  tdata_d  = wdata_q[UART_DLEN-1:0];
                  bresp_d  = RESP_OKAY;
                end else begin
                  bresp_d = RESP_SLVERR;
                end
              end
              OFF_STATUS: bresp_d = RESP_SLVERR;
              OFF_CTRL: begin
                ctrl_d  = ((ctrl_q & ~wmask) | (wdata_q & wmask)) & CTRL_MASK;
                bresp_d = RESP_OKAY;
              end
              OFF_IRQ: begin
                err_clr = wstrb_q[0] & wdata_q[IRQ_ERR];
                bresp_d = RESP_OKAY;
              end
              default: bresp_d = RESP_DECERR;
            endcase
          end
        end
      end
      W_TX: begin
        if (i_txb_tready) wstate_d = W_RESP;
      end
      W_RESP: begin
        if (i_axi_bready) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Read path: RX data is popped in a dedicated cycle so tready is a clean pulse.
  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        if (i_axi_arvalid && o_axi_arready) begin
          rstate_d = R_RESP;
          rdata_d  = '0;
          if (!in_window(i_axi_araddr)) begin
            rresp_d = RESP_DECERR;
          end else begin
            case (i_axi_araddr[3:0])
              OFF_DATA: begin
                if (i_rxb_tvalid && ctrl_q[CTRL_RXEN]) begin
                  rstate_d = R_POP;
                  rresp_d  = RESP_OKAY;
                end else begin
                  rresp_d = RESP_SLVERR;
                end
              end
              OFF_STATUS: begin
                rdata_d = status_val;
                rresp_d = RESP_OKAY;
              end
              OFF_CTRL: begin
                rdata_d = ctrl_q;
                rresp_d = RESP_OKAY;
              end
              OFF_IRQ: begin
                rdata_d = {{(AXI_DLEN-3){1'b0}}, err_q, i_rxb_tvalid, i_txb_tready};
                rresp_d = RESP_OKAY;
              end
              default: rresp_d = RESP_DECERR;
            endcase
          end
        end
      end
      R_POP: begin
        rdata_d  = AXI_DLEN'(i_rxb_tdata);
        rstate_d = R_RESP;
      end
      R_RESP: begin
        if (i_axi_rready) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // irq uses next-state pending so it rises one cycle after an rx_err pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ready_q  <= 1'b0;
      wstate_q <= W_IDLE;
      aw_got_q <= 1'b0;
      w_got_q  <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RESP_OKAY;
      tdata_q  <= '0;
      ctrl_q   <= '0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
      rstate_q <= R_IDLE;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      ready_q  <= 1'b1;
      wstate_q <= wstate_d;
      aw_got_q <= aw_got_d;
      w_got_q  <= w_got_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bresp_q  <= bresp_d;
      tdata_q  <= tdata_d;
      ctrl_q   <= ctrl_d;
      err_q    <= err_d;
      irq_q    <= |(pending_d & ctrl_q[CTRL_IRQEN_LSB +: 3]);
      rstate_q <= rstate_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  assign o_axi_awready = ready_q && (wstate_q == W_IDLE) && !aw_got_q;
  assign o_axi_wready  = ready_q && (wstate_q == W_IDLE) && !w_got_q;
  assign o_axi_bvalid  = (wstate_q == W_RESP);
  assign o_axi_bresp   = bresp_q;
  assign o_axi_arready = ready_q && (rstate_q == R_IDLE);
  assign o_axi_rvalid  = (rstate_q == R_RESP);
  assign o_axi_rdata   = rdata_q;
  assign o_axi_rresp   = rresp_q;
  assign o_txb_tvalid  = (wstate_q == W_TX);
  assign o_txb_tdata   = tdata_q;
  assign o_rxb_tready  = (rstate_q == R_POP);
  assign o_irq         = irq_q;
  assign o_tx_en       = ctrl_q[CTRL_TXEN];
  assign o_rx_en       = ctrl_q[CTRL_RXEN];
  assign o_baud_div    = ctrl_q[CTRL_BAUD_LSB +: 16];

endmodule

// File: tb/tb_uart_axil_ctrl.sv
// Directed scoreboard bench for uart_axil_ctrl: AXI responses and TX bytes
// are queued as expectations when issued and checked when the DUT answers.
module tb_uart_axil_ctrl;
  import uart_pkg::*;

  logic        clk;
  logic        rstn;
  logic        i_axi_awvalid, o_axi_awready;
  logic [31:0] i_axi_awaddr;
  logic        i_axi_wvalid, o_axi_wready;
  logic [31:0] i_axi_wdata;
  logic [3:0]  i_axi_wstrb;
  logic        o_axi_bvalid, i_axi_bready;
  logic [1:0]  o_axi_bresp;
  logic        i_axi_arvalid, o_axi_arready;
  logic [31:0] i_axi_araddr;
  logic        o_axi_rvalid, i_axi_rready;
  logic [31:0] o_axi_rdata;
  logic [1:0]  o_axi_rresp;
  logic        o_txb_tvalid, i_txb_tready;
  logic [7:0]  o_txb_tdata;
  logic        i_rxb_tvalid, o_rxb_tready;
  logic [7:0]  i_rxb_tdata;
  logic        i_rx_err, o_irq, o_tx_en, o_rx_en;
  logic [15:0] o_baud_div;

  typedef struct {
    string       tag;
    logic [1:0]  resp;
    logic [31:0] data;
  } expect_t;

  expect_t    wrQ[$];
  expect_t    rdQ[$];
  logic [7:0] txQ[$];
  logic [7:0] txExp;
  int         checks = 0;
  int         failures = 0;
  int         txHs = 0;
  int         rxPops = 0;
  int         snapTx, snapRx;

  uart_axil_ctrl #(
    .AXI_ALEN(32), .AXI_DLEN(32), .UART_DLEN(8), .BASE_ADDR(32'h0)
  ) dut (
    .clk(clk), .rstn(rstn),
    .i_axi_awvalid(i_axi_awvalid), .o_axi_awready(o_axi_awready), .i_axi_awaddr(i_axi_awaddr),
    .i_axi_wvalid(i_axi_wvalid), .o_axi_wready(o_axi_wready), .i_axi_wdata(i_axi_wdata),
    .i_axi_wstrb(i_axi_wstrb),
    .o_axi_bvalid(o_axi_bvalid), .i_axi_bready(i_axi_bready), .o_axi_bresp(o_axi_bresp),
    .i_axi_arvalid(i_axi_arvalid), .o_axi_arready(o_axi_arready), .i_axi_araddr(i_axi_araddr),
    .o_axi_rvalid(o_axi_rvalid), .i_axi_rready(i_axi_rready), .o_axi_rdata(o_axi_rdata),
    .o_axi_rresp(o_axi_rresp),
    .o_txb_tvalid(o_txb_tvalid), .i_txb_tready(i_txb_tready), .o_txb_tdata(o_txb_tdata),
    .i_rxb_tvalid(i_rxb_tvalid), .o_rxb_tready(o_rxb_tready), .i_rxb_tdata(i_rxb_tdata),
    .i_rx_err(i_rx_err), .o_irq(o_irq), .o_tx_en(o_tx_en), .o_rx_en(o_rx_en),
    .o_baud_div(o_baud_div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Stream-side monitor: every TX handshake must match the oldest queued byte.
  always @(posedge clk) begin
    if (o_txb_tvalid && i_txb_tready) begin
      txHs++;
      if (txQ.size() == 0) begin
        checkOutput("tx_unexpected", 32'(txQ.size()), 32'd1);
      end else begin
        txExp = txQ.pop_front();
        checkOutput("tx_data", 32'(o_txb_tdata), 32'(txExp));
      end
    end
    if (o_rxb_tready) rxPops++;
  end

  task automatic applyStimulus(input bit isWrite, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input int awLag, input int wLag,
                               input logic [1:0] resp, input logic [31:0] rdExp, input string tag);
    expect_t e;
    bit aDone = 1'b0;
    bit dDone = !isWrite;
    bit aHs, dHs;
    int cyc = 0;
    e.tag = tag; e.resp = resp; e.data = rdExp;
    if (isWrite) wrQ.push_back(e); else rdQ.push_back(e);
    @(negedge clk);
    while ((!aDone || !dDone) && cyc < 100) begin
      if (isWrite) begin
        if (!aDone && cyc == awLag) begin i_axi_awvalid = 1'b1; i_axi_awaddr = addr; end
        if (!dDone && cyc == wLag) begin
          i_axi_wvalid = 1'b1; i_axi_wdata = data; i_axi_wstrb = strb;
        end
        aHs = i_axi_awvalid && o_axi_awready;
        dHs = i_axi_wvalid && o_axi_wready;
      end else begin
        if (cyc == 0) begin i_axi_arvalid = 1'b1; i_axi_araddr = addr; end
        aHs = i_axi_arvalid && o_axi_arready;
        dHs = 1'b0;
      end
      @(negedge clk);
      if (aHs) begin
        aDone = 1'b1;
        if (isWrite) i_axi_awvalid = 1'b0; else i_axi_arvalid = 1'b0;
      end
      if (dHs) begin dDone = 1'b1; i_axi_wvalid = 1'b0; end
      cyc++;
    end
    checkOutput({tag, "_addr_hs"}, 32'(aDone && dDone), 32'd1);
  endtask

  task automatic collectWrite(input int hold);
    expect_t e;
    int cyc = 0;
    e = wrQ.pop_front();
    while (!o_axi_bvalid && cyc < 100) begin @(negedge clk); cyc++; end
    checkOutput({e.tag, "_bresp"}, {29'd0, o_axi_bvalid, o_axi_bresp}, {29'd0, 1'b1, e.resp});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput({e.tag, "_bhold"}, {29'd0, o_axi_bvalid, o_axi_bresp}, {29'd0, 1'b1, e.resp});
    end
    i_axi_bready = 1'b1;
    @(negedge clk);
    i_axi_bready = 1'b0;
    checkOutput({e.tag, "_bdone"}, 32'(o_axi_bvalid), 32'd0);
  endtask

  task automatic collectRead(input int hold);
    expect_t e;
    int cyc = 0;
    e = rdQ.pop_front();
    while (!o_axi_rvalid && cyc < 100) begin @(negedge clk); cyc++; end
    checkOutput({e.tag, "_rresp"}, {29'd0, o_axi_rvalid, o_axi_rresp}, {29'd0, 1'b1, e.resp});
    checkOutput({e.tag, "_rdata"}, o_axi_rdata, e.data);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput({e.tag, "_rhold"}, {29'd0, o_axi_rvalid, o_axi_rresp}, {29'd0, 1'b1, e.resp});
      checkOutput({e.tag, "_rdhold"}, o_axi_rdata, e.data);
    end
    i_axi_rready = 1'b1;
    @(negedge clk);
    i_axi_rready = 1'b0;
    checkOutput({e.tag, "_rdone"}, 32'(o_axi_rvalid), 32'd0);
  endtask

  task automatic waitTvalid(input string tag);
    int cyc = 0;
    while (!o_txb_tvalid && cyc < 20) begin @(negedge clk); cyc++; end
    checkOutput({tag, "_tvalid"}, 32'(o_txb_tvalid), 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstn = 1'b0;
    i_axi_awvalid = 0; i_axi_awaddr = 0; i_axi_wvalid = 0; i_axi_wdata = 0; i_axi_wstrb = 0;
    i_axi_bready = 0; i_axi_arvalid = 0; i_axi_araddr = 0; i_axi_rready = 0;
    i_txb_tready = 0; i_rxb_tvalid = 0; i_rxb_tdata = 0; i_rx_err = 0;

    // Reset values, then ready rising on the first edge after release.
    repeat (3) @(negedge clk);
    checkOutput("rst_readys", {29'd0, o_axi_awready, o_axi_wready, o_axi_arready}, 32'd0);
    checkOutput("rst_valids", {28'd0, o_axi_bvalid, o_axi_rvalid, o_txb_tvalid, o_rxb_tready}, 32'd0);
    checkOutput("rst_resps", {28'd0, o_axi_bresp, o_axi_rresp}, 32'd0);
    checkOutput("rst_rdata", o_axi_rdata, 32'd0);
    checkOutput("rst_tdata", 32'(o_txb_tdata), 32'd0);
    checkOutput("rst_ctrl", {13'd0, o_irq, o_tx_en, o_rx_en, o_baud_div}, 32'd0);
    rstn = 1'b1;
    #1 checkOutput("awready_pre_edge", 32'(o_axi_awready), 32'd0);
    @(negedge clk);
    checkOutput("readys_first_edge", {29'd0, o_axi_awready, o_axi_wready, o_axi_arready}, 32'd7);

    applyStimulus(1, 32'h8, 32'h0001_0003, 4'hF, 0, 0, RESP_OKAY, 0, "ctrl_init");
    collectWrite(0);
    checkOutput("ctrl_mirror", {14'd0, o_tx_en, o_rx_en, o_baud_div}, {14'd0, 1'b1, 1'b1, 16'h0001});
    applyStimulus(0, 32'h8, 0, 0, 0, 0, RESP_OKAY, 32'h0001_0003, "ctrl_read");
    collectRead(0);

    // TX byte with AW leading W by two cycles and a stalled consumer.
    snapTx = txHs;
    txQ.push_back(8'h5A);
    applyStimulus(1, 32'h0, 32'h0000_005A, 4'h1, 0, 2, RESP_OKAY, 0, "tx_write");
    waitTvalid("tx_write");
    for (int i = 0; i < 3; i++) begin
      checkOutput("tx_hold", {23'd0, o_axi_bvalid, o_txb_tvalid, o_txb_tdata}, {23'd0, 1'b0, 1'b1, 8'h5A});
      @(negedge clk);
    end
    i_txb_tready = 1'b1;
    @(negedge clk);
    i_txb_tready = 1'b0;
    checkOutput("tx_one_hs", 32'(txHs - snapTx), 32'd1);
    collectWrite(0);

    // Byte-strobed CTRL write with W arriving before AW.
    applyStimulus(1, 32'h8, 32'h0005_FFFF, 4'b0100, 1, 0, RESP_OKAY, 0, "ctrl_byte2");
    collectWrite(0);
    checkOutput("ctrl_byte2_mirror", {14'd0, o_tx_en, o_rx_en, o_baud_div}, {14'd0, 1'b1, 1'b1, 16'h0005});

    // RX pop, then an empty read.
    i_rxb_tvalid = 1'b1; i_rxb_tdata = 8'hA5;
    snapRx = rxPops;
    applyStimulus(0, 32'h0, 0, 0, 0, 0, RESP_OKAY, 32'h0000_00A5, "rx_pop");
    collectRead(0);
    checkOutput("rx_one_pop", 32'(rxPops - snapRx), 32'd1);
    i_rxb_tvalid = 1'b0;
    snapRx = rxPops;
    applyStimulus(0, 32'h0, 0, 0, 0, 0, RESP_SLVERR, 32'd0, "rx_empty");
    collectRead(0);
    checkOutput("rx_no_pop", 32'(rxPops - snapRx), 32'd0);

    // Error responses leave CTRL and the TX stream untouched.
    snapTx = txHs;
    applyStimulus(1, 32'h20, 32'hFFFF_FFFF, 4'hF, 0, 0, RESP_DECERR, 0, "wr_oow");
    collectWrite(0);
    applyStimulus(1, 32'h4, 32'hFFFF_FFFF, 4'hF, 0, 0, RESP_SLVERR, 0, "wr_status");
    collectWrite(0);
    applyStimulus(1, 32'h9, 32'hFFFF_FFFF, 4'hF, 0, 0, RESP_DECERR, 0, "wr_unaligned");
    collectWrite(0);
    applyStimulus(1, 32'h0, 32'h0000_0077, 4'b0010, 0, 0, RESP_SLVERR, 0, "wr_data_nostrb");
    collectWrite(0);
    applyStimulus(0, 32'h14, 0, 0, 0, 0, RESP_DECERR, 32'd0, "rd_oow");
    collectRead(0);
    applyStimulus(0, 32'h8, 0, 0, 0, 0, RESP_OKAY, 32'h0005_0003, "ctrl_unchanged");
    collectRead(0);
    checkOutput("err_no_tx", 32'(txHs - snapTx), 32'd0);

    // Error interrupt: set, W1C, and set winning over a coincident clear.
    applyStimulus(1, 32'h8, 32'h0000_0013, 4'h1, 0, 0, RESP_OKAY, 0, "irq_en");
    collectWrite(0);
    checkOutput("irq_idle", 32'(o_irq), 32'd0);
    i_rx_err = 1'b1;
    @(negedge clk);
    i_rx_err = 1'b0;
    checkOutput("irq_set", 32'(o_irq), 32'd1);
    applyStimulus(0, 32'h4, 0, 0, 0, 0, RESP_OKAY, 32'h0000_0004, "status_err");
    collectRead(0);
    applyStimulus(0, 32'hC, 0, 0, 0, 0, RESP_OKAY, 32'h0000_0004, "irq_pending");
    collectRead(0);
    applyStimulus(1, 32'hC, 32'h0000_0004, 4'h1, 0, 0, RESP_OKAY, 0, "irq_w1c");
    collectWrite(0);
    checkOutput("irq_cleared", 32'(o_irq), 32'd0);
    applyStimulus(1, 32'hC, 32'h0000_0004, 4'h1, 0, 0, RESP_OKAY, 0, "irq_race");
    i_rx_err = 1'b1;
    @(negedge clk);
    i_rx_err = 1'b0;
    collectWrite(0);
    checkOutput("irq_race_set", 32'(o_irq), 32'd1);
    applyStimulus(0, 32'hC, 0, 0, 0, 0, RESP_OKAY, 32'h0000_0004, "irq_race_pend");
    collectRead(0);
    applyStimulus(1, 32'hC, 32'h0000_0004, 4'h1, 0, 0, RESP_OKAY, 0, "irq_w1c2");
    collectWrite(0);
    checkOutput("irq_cleared2", 32'(o_irq), 32'd0);

    // Concurrent write and read with both masters stalling their responses.
    i_txb_tready = 1'b1; i_rxb_tvalid = 1'b1;
    fork
      applyStimulus(1, 32'h8, 32'h0005_0003, 4'hF, 0, 0, RESP_OKAY, 0, "conc_wr");
      applyStimulus(0, 32'h4, 0, 0, 0, 0, RESP_OKAY, 32'h0000_0003, "conc_rd");
    join
    fork
      collectWrite(5);
      collectRead(5);
    join
    i_txb_tready = 1'b0; i_rxb_tvalid = 1'b0;

    // Reset while a TX byte is waiting for the consumer.
    snapTx = txHs;
    applyStimulus(1, 32'h0, 32'h0000_0033, 4'h1, 0, 0, RESP_OKAY, 0, "tx_abort");
    waitTvalid("tx_abort");
    rstn = 1'b0;
    #1 checkOutput("abort_tvalid", {30'd0, o_txb_tvalid, o_axi_awready}, 32'd0);
    wrQ.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("abort_awready", 32'(o_axi_awready), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("abort_quiet", {29'd0, o_axi_bvalid, o_txb_tvalid, o_tx_en}, 32'd0);
    checkOutput("abort_rdata", o_axi_rdata, 32'd0);
    checkOutput("abort_no_tx", 32'(txHs - snapTx), 32'd0);

    // DATA write with the transmitter disabled after reset.
    applyStimulus(1, 32'h0, 32'h0000_0011, 4'h1, 0, 0, RESP_SLVERR, 0, "tx_disabled");
    collectWrite(0);
    checkOutput("tx_disabled_no_tx", 32'(txHs - snapTx), 32'd0);

    checkOutput("sb_drain", 32'(wrQ.size() + rdQ.size() + txQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_axil_ctrl.md
UART_AXIL_CTRL -- requirements
Module: uart_axil_ctrl

Interface
REQ-001 Parameter: AXI_ALEN, 32, AXI address width.
REQ-002 Parameter: AXI_DLEN, 32, AXI data width; only 32 is supported.
REQ-003 Parameter: UART_DLEN, 8, UART character width, legal range 5..9.
REQ-004 Parameter: BASE_ADDR, 32'h0, register-window base; 16-byte aligned.
REQ-005 Ports: clk in 1 clock; rstn in 1 reset, asynchronous and active-low.
REQ-006 AXI-Lite slave ports: i_axi_awvalid/o_axi_awready/i_axi_awaddr[AXI_ALEN]; i_axi_wvalid/o_axi_wready/i_axi_wdata[32]/i_axi_wstrb[4]; o_axi_bvalid/i_axi_bready/o_axi_bresp[2]; i_axi_arvalid/o_axi_arready/i_axi_araddr[AXI_ALEN]; o_axi_rvalid/i_axi_rready/o_axi_rdata[32]/o_axi_rresp[2].
REQ-007 TX stream ports: o_txb_tvalid out 1; i_txb_tready in 1; o_txb_tdata out UART_DLEN.
REQ-008 RX stream ports: i_rxb_tvalid in 1; o_rxb_tready out 1; i_rxb_tdata in UART_DLEN.
REQ-009 Ports: i_rx_err in 1, one-cycle framing-error pulse; o_irq out 1, level interrupt.
REQ-010 Ports: o_tx_en out 1; o_rx_en out 1; o_baud_div out 16, mirrors of CTRL.

Function
REQ-011 Register map, offsets from BASE_ADDR: 0x0 DATA; 0x4 STATUS (RO); 0x8 CTRL (RW); 0xC IRQ (RW).
REQ-012 Bits: STATUS[0]=i_txb_tready, [1]=i_rxb_tvalid, [2]=err_sticky. CTRL[0]=tx_en, [1]=rx_en, [4:2]=irq_en, [31:16]=baud_div. IRQ[2:0]=pending, W1C.
REQ-013 Write FSM states: W_IDLE, W_TX, W_RESP.
REQ-014 In W_IDLE, AW and W SHALL be accepted independently, each with ready=1 until captured, in either order or the same cycle.
REQ-015 Once both AW and W are captured, the block SHALL decode in one cycle.
REQ-016 A DATA write with wstrb[0]=1 and tx_en=1 SHALL go to W_TX, driving o_txb_tvalid=1 with wdata[UART_DLEN-1:0] held stable until i_txb_tready; then W_RESP with OKAY.
REQ-017 Any other write SHALL go directly to W_RESP.
REQ-018 A CTRL/IRQ write SHALL apply per byte strobe, with OKAY.
REQ-019 DATA with wstrb[0]=0, DATA with tx_en=0, and STATUS writes SHALL return SLVERR (2'b10) with no side effect.
REQ-020 An address outside BASE_ADDR..BASE_ADDR+0xF or not word-aligned SHALL return DECERR (2'b11).
REQ-021 W_RESP SHALL hold o_axi_bvalid with a stable bresp until i_axi_bready, then return to W_IDLE. Only one write is outstanding.
REQ-022 Read FSM states: R_IDLE, R_POP, R_RESP. o_axi_arready=1 only in R_IDLE.
REQ-023 A DATA read with i_rxb_tvalid=1 and rx_en=1 SHALL go to R_POP: o_rxb_tready=1 for exactly one cycle, capture i_rxb_tdata zero-extended, OKAY.
REQ-024 A DATA read with the RX buffer empty or rx_en=0 SHALL return rdata=0 with SLVERR and no pop.
REQ-025 STATUS/CTRL/IRQ reads SHALL return the register value with OKAY.
REQ-026 An out-of-window read SHALL return rdata=0 with DECERR.
REQ-027 R_RESP SHALL hold rvalid, rdata and rresp stable until i_axi_rready.
REQ-028 Read and write FSMs are independent and may run concurrently.
REQ-029 pending[0]=i_txb_tready and pending[1]=i_rxb_tvalid are levels; pending[2]=err_sticky, set by i_rx_err and cleared by W1C of bit 2.
REQ-030 When i_rx_err and a W1C of bit 2 occur in the same cycle, set SHALL win.
REQ-031 o_irq SHALL be registered: OR of (pending & irq_en), asserted one cycle after the cause.
REQ-032 o_tx_en, o_rx_en and o_baud_div SHALL be driven directly from CTRL flops.

Reset
REQ-033 While rstn=0: all ready/valid outputs 0; bresp/rresp 2'b00; o_axi_rdata 0; o_txb_tdata 0; CTRL=32'h0000_0000; err_sticky=0; o_irq=0; FSMs in W_IDLE/R_IDLE.
REQ-034 Reset mid-transaction SHALL abandon it without emitting a TX or RX handshake.
REQ-035 o_axi_awready, o_axi_wready and o_axi_arready SHALL rise on the first clk edge after rstn deasserts.

Structure
REQ-036 Package uart_pkg SHALL hold the register-offset constants, bit-index constants, AXI response codes (OKAY/SLVERR/DECERR), and the write/read state enums.
REQ-037 There SHALL be no sub-modules; the register file and both FSMs reside in uart_axil_ctrl.

Verification
REQ-038 CTRL=0x0001_0003, then AW 2 cycles before W to 0x0, wdata=0x5A, strb=0x1, txb_tready low 3 cycles -> tvalid held 3 cycles with tdata=0x5A, one handshake, then bvalid with OKAY.
REQ-039 rxb_tvalid=1, tdata=0xA5, read 0x0 -> o_rxb_tready pulses exactly 1 cycle, rdata=0xA5, OKAY; a repeat read with rxb_tvalid=0 -> rdata=0, SLVERR, no tready.
REQ-040 Write to 0x20 -> DECERR; write 0x4 -> SLVERR; read 0x14 -> rdata=0, DECERR; CTRL unchanged.
REQ-041 irq_en=3'b100, i_rx_err pulse -> o_irq=1 one cycle later; W1C 0x4 to IRQ -> o_irq=0; i_rx_err coincident with the W1C -> bit stays set.
REQ-042 Concurrent write to CTRL and read of STATUS with bready/rready held low 5 cycles -> both responses held stable, both complete.
REQ-043 rstn asserted while in W_TX -> tvalid=0 immediately, no bvalid after release, awready=1 on the first edge.
